ud_win_counter: RTL
===================

# ud_win_counter

Parametrised up/down counter for the feedback path: the next generation of the fixed 16-bit midscale-reset up/down counter. It adds a width parameter, a programmable reset value, a programmable integration window with snapshot output and optional restart, and optional saturation at the rails. It sits between the comparator/decision bit (`u_d`) and the DAC/readout logic that consumes windowed counts.

## Interface

Parameters:
- `WIDTH`, default 16: counter width in bits, minimum 2.
- `WIN_W`, default 8: width of the window-length counter.
- `RESET_VAL`, default `1 << (WIDTH-1)`: midscale. Value loaded on reset and on window restart.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rstb`  in  1: asynchronous, active-low reset.
- `en`  in  1: count enable. When low, all counting and window state holds.
- `u_d`  in  1: direction. 1 = count up (+1), 0 = count down (−1).
- `win_len`  in  `WIN_W`: window length minus 1, measured in enabled cycles.
- `win_clr`  in  1: 1 = reload `RESET_VAL` into `q` at each window end.
- `q`  out  `WIDTH`: live counter value, registered.
- `dout`  out  `WIDTH`: window snapshot, registered.
- `dout_vld`  out  1: one-cycle pulse when `dout` updates.
- `sat_hi`  out  1: sticky per-window flag; an up step was blocked at all-ones.
- `sat_lo`  out  1: sticky per-window flag; a down step was blocked at zero.

## Operation

- **Reset** (`rstb` = 0, asynchronous): `q` = `RESET_VAL`, `dout` = `RESET_VAL`, `dout_vld` = 0, internal `win_cnt` = 0, `sat_hi` = 0, `sat_lo` = 0.
- **Step:** on each edge with `en` = 1, `q_next` = `q` ± 1 according to `u_d`. Arithmetic is modulo 2^`WIDTH` unless saturation is compiled in (see Configuration).
- **Window end:** occurs on an enabled edge where `win_cnt >= win_len`. On that edge:
  - `dout` <= `q_next`, the value including this cycle's step.
  - `dout_vld` <= 1.
  - `win_cnt` <= 0.
  - `q` <= `RESET_VAL` if `win_clr` = 1, otherwise `q` <= `q_next`.
- **Other enabled edges:** `win_cnt` <= `win_cnt` + 1; `q` <= `q_next`.
- **`dout_vld`** is 0 on every edge that is not a window end. This includes edges with `en` = 0.
- **`win_len` = 0:** every enabled edge is a window end, so `dout_vld` stays high continuously while `en` = 1.
- **`win_len` lowered mid-window below `win_cnt`:** the window ends on the next enabled edge, because the end condition uses `>=`.
- **Input sampling:** `win_clr`, `win_len` and `u_d` are sampled on the edge itself. No shadow registers.
- **Sticky flags:** `sat_hi`/`sat_lo` are cleared on a window-end edge, except that a block occurring on that same edge sets the flag (set wins). Their values before the clear belong to the window just reported in `dout`.

## Timing

- `q` latency: 1 cycle from an enabled edge.
- `dout`/`dout_vld` latency: valid in the cycle following the window-end edge.
- Window period: `win_len`+1 enabled edges. Disabled cycles stretch the window without counting.
- Reset mid-window: all state returns to reset values immediately. The partial window is discarded and no `dout_vld` is produced.
- `en` deasserted on what would have been the window-end edge: no end, no pulse. The window ends on the next enabled edge.

## Configuration

- Macro: `UDC_SAT_EN`.
- **Defined:**
  - An up step at `q` = 2^`WIDTH`−1 holds `q` and sets `sat_hi`.
  - A down step at `q` = 0 holds `q` and sets `sat_lo`.
  - `dout` captures the held value.
- **Undefined:**
  - `q` wraps modulo 2^`WIDTH`, matching legacy counter behaviour.
  - `sat_hi` and `sat_lo` are tied to 0.

## Test plan

All scenarios use `WIDTH`=16, `WIN_W`=8, default `RESET_VAL` unless stated.

1. **Reset:** `rstb` low asynchronously mid-cycle -> `q`=0x8000, `dout`=0x8000, `dout_vld`=0 immediately.
2. **Up window, no restart:** `en`=1, `u_d`=1, `win_len`=9, `win_clr`=0 for 20 edges -> `dout_vld` pulses after edge 10 with `dout`=0x800A, and after edge 20 with `dout`=0x8014; `q`=0x8014.
3. **Down window with restart:** `u_d`=0, `win_len`=3, `win_clr`=1 -> after edge 4, `dout`=0x7FFC and `q`=0x8000; this repeats every 4 edges.
4. **Enable gating:** `en`=0 for 5 cycles inside a window -> `q` and `win_cnt` hold, no `dout_vld`; the window completes 5 cycles late with the same `dout` value.
5. **Saturation:** `WIDTH`=4, `RESET_VAL`=8, `win_len`=15, `u_d`=1 for 10 edges:
   - With `UDC_SAT_EN`: `q`=15 from edge 7 onward and `sat_hi`=1.
   - Without: `q`=2 and `sat_hi`=0.
6. **Reset mid-window:** pulse `rstb` low after 5 enabled edges of a `win_len`=9 window -> no `dout_vld`; the next window completes 10 enabled edges after reset release with `dout`=0x800A (`u_d`=1).

Source files
------------

// File: rtl/ud_win_counter_if.sv
// ud_win_counter_if
// Bus between the decision logic and the windowed up/down counter.
//   en       : count enable (holds all counting and window state when low)
//   u_d      : direction, 1 = up, 0 = down
//   win_len  : window length minus 1, in enabled cycles
//   win_clr  : reload the reset value into q at each window end
//   q        : live counter value
//   dout     : window snapshot
//   dout_vld : one-cycle pulse when dout updates
//   sat_hi   : sticky per-window flag, up step blocked at all-ones
//   sat_lo   : sticky per-window flag, down step blocked at zero
// master drives the controls, slave is the counter.
interface ud_win_counter_if #(
    parameter int WIDTH = 16,
    parameter int WIN_W = 8
);
    logic             en;
    logic             u_d;
    logic [WIN_W-1:0] win_len;
    logic             win_clr;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] dout;
    logic             dout_vld;
    logic             sat_hi;
    logic             sat_lo;

    modport master (
        output en, u_d, win_len, win_clr,
        input  q, dout, dout_vld, sat_hi, sat_lo
    );

    modport slave (
        input  en, u_d, win_len, win_clr,
        output q, dout, dout_vld, sat_hi, sat_lo
    );
endinterface

// File: rtl/ud_win_counter.sv
// ud_win_counter
// Parametrised up/down counter with a programmable integration window.
// Every window of win_len+1 enabled cycles, the value including that
// cycle's step is captured into dout and dout_vld pulses for one cycle;
// with win_clr set, q restarts from RESET_VAL at the window end.
// Ports:
//   clk  : clock, rising edge
//   rstb : asynchronous active-low reset
//   bus  : ud_win_counter_if.slave (en, u_d, win_len, win_clr in;
//          q, dout, dout_vld, sat_hi, sat_lo out)
// Build option:
//   UDC_SAT_EN defined   : q saturates at 0 and all-ones, sat_hi/sat_lo
//                          record blocked steps per window.
//   UDC_SAT_EN undefined : q wraps modulo 2^WIDTH, sat_hi/sat_lo are 0.
module ud_win_counter #(
    parameter int               WIDTH     = 16,
    parameter int               WIN_W     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {1'b1, {(WIDTH-1){1'b0}}}
) (
    input logic              clk,
    input logic              rstb,
    ud_win_counter_if.slave  bus
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    // One step of the counter, holding at the rails when saturation is built in.
    function automatic logic [WIDTH-1:0] f_step(input logic [WIDTH-1:0] q, input logic up);
        logic [WIDTH-1:0] n;
        n = up ? (q + ONE) : (q - ONE);
`ifdef UDC_SAT_EN
        if (up && (q == '1)) n = q;
        if (!up && (q == '0)) n = q;
`endif
        return n;
    endfunction

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_dout;
    logic             r_dout_vld;
    logic [WIN_W-1:0] r_win_cnt;

    logic [WIDTH-1:0] w_q_next;
    logic             w_win_end;

    assign w_q_next  = f_step(r_q, bus.u_d);
    // >= so that lowering win_len below the current count ends the window at once.
    assign w_win_end = bus.en && (r_win_cnt >= bus.win_len);

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_q        <= RESET_VAL;
            r_dout     <= RESET_VAL;
            r_dout_vld <= 1'b0;
            r_win_cnt  <= '0;
        end else begin
            r_dout_vld <= 1'b0;
            if (w_win_end) begin
                r_dout     <= w_q_next;
                r_dout_vld <= 1'b1;
                r_win_cnt  <= '0;
                r_q        <= bus.win_clr ? RESET_VAL : w_q_next;
            end else if (bus.en) begin
                r_win_cnt  <= r_win_cnt + WIN_W'(1);
                r_q        <= w_q_next;
            end
        end
    end

`ifdef UDC_SAT_EN
    logic w_blk_hi;
    logic w_blk_lo;
    logic r_sat_hi;
    logic r_sat_lo;

    assign w_blk_hi = bus.en &&  bus.u_d && (r_q == '1);
    assign w_blk_lo = bus.en && !bus.u_d && (r_q == '0);

    // Flags restart at each window end, but a block on that same edge still sets them.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_sat_hi <= 1'b0;
            r_sat_lo <= 1'b0;
        end else if (w_win_end) begin
            r_sat_hi <= w_blk_hi;
            r_sat_lo <= w_blk_lo;
        end else begin
            r_sat_hi <= r_sat_hi | w_blk_hi;
            r_sat_lo <= r_sat_lo | w_blk_lo;
        end
    end

    assign bus.sat_hi = r_sat_hi;
    assign bus.sat_lo = r_sat_lo;
`else
    assign bus.sat_hi = 1'b0;
    assign bus.sat_lo = 1'b0;
`endif

    assign bus.q        = r_q;
    assign bus.dout     = r_dout;
    assign bus.dout_vld = r_dout_vld;

endmodule
